te_block_scheduler: RTL and testbench
=====================================

// Module: te_block_scheduler
// PURPOSE
// Sequences the N parallel trace blocks produced each cycle by multiple_retirement into the
//   single-block-per-cycle input of the trace encoder.
// Buffers whole retirement groups in a FIFO and drains the valid slots lowest-index first.
// Uses a valid/ready handshake toward the encoder and reports lost groups upstream.
// PARAMETERS
// N      2  blocks per group; equals the N of multiple_retirement; >=1
// DEPTH  4  FIFO depth in groups; power of two, >=2
// (IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, XLEN, PRIV_LEN come from mure_pkg)
// PORTS
// clk_i        in   1                 clock
// rst_i        in   1                 asynchronous reset, active-high
// valid_i      in   N                 per-slot valid from multiple_retirement
// iretire_i    in   N*IRETIRE_LEN     per-slot retired-halfword count
// ilastsize_i  in   N                 per-slot last-instruction size
// itype_i      in   N*ITYPE_LEN       per-slot itype
// iaddr_i      in   N*XLEN            per-slot iaddr
// cause_i      in   CAUSE_LEN         group cause, shared by all slots
// tval_i       in   XLEN              group tval, shared by all slots
// priv_i       in   PRIV_LEN          group privilege level
// ready_i      in   1                 encoder accepts the current block
// valid_o      out  1                 block presented to encoder
// iretire_o    out  IRETIRE_LEN       selected slot iretire
// ilastsize_o  out  1                 selected slot ilastsize
// itype_o      out  ITYPE_LEN         selected slot itype
// iaddr_o      out  XLEN              selected slot iaddr
// cause_o      out  CAUSE_LEN         head-group cause
// tval_o       out  XLEN              head-group tval
// priv_o       out  PRIV_LEN          head-group priv
// full_o       out  1                 FIFO holds DEPTH groups
// overflow_o   out  1                 one-cycle pulse: an incoming group was dropped
// occupancy_o  out  $clog2(DEPTH+1)   groups stored, including the partly drained head
// BEHAVIOUR
// Reset (async):
//   - wr_ptr, rd_ptr, count and slot index are cleared; FSM goes to IDLE.
//   - All outputs read 0 while rst_i is high, including a reset mid-drain; stored groups are discarded.
// Push:
//   - A group is pushed at the clock edge when |valid_i is set and either count<DEPTH or a pop happens in the same cycle.
//   - The whole group is stored, including its valid mask.
//   - A group with valid_i==0 is ignored.
// Drop:
//   - If |valid_i is set, count==DEPTH and no pop happens, the group is discarded.
//   - overflow_o is registered and is 1 in the following cycle only.
// FSM IDLE:
//   - Entered when count==0; valid_o=0.
//   - Moves to SERVE when count becomes non-zero; the slot index loads the lowest set bit of the new head mask.
// FSM SERVE:
//   - valid_o=1; outputs show slot[sel] of the head group, plus the head group's cause, tval and priv.
//   - A transfer occurs when valid_o && ready_i.
//   - On transfer, sel advances to the next set bit above sel, skipping cleared slots.
//   - If sel is the highest set bit, the head is popped: rd_ptr+1 (wraps mod DEPTH) and count-1.
//   - After a pop, sel loads the lowest set bit of the new head; if the FIFO is now empty, go to IDLE.
// Output timing:
//   - Latency: a group pushed at edge k is visible on valid_o after edge k (one cycle) when the FIFO was empty.
//   - A cycle with valid_o && !ready_i leaves all data outputs stable until the transfer.
// Simultaneous push and pop:
//   - count is unchanged; the push is accepted even when full.
//   - Pointers wrap independently, modulo DEPTH.
// Status outputs:
//   - full_o = (count==DEPTH).
//   - occupancy_o = count.
// Throughput: at most one block per cycle; a group of k set slots needs k transfers.
// TESTING
// 1. Single group: valid_i=2'b11, iaddr={0x80000010,0x80000000}, ready_i=1
//    -> valid_o for 2 cycles; iaddr_o 0x80000000 then 0x80000010; occupancy 1 -> 0.
// 2. Sparse mask: valid_i=2'b10 -> exactly one transfer, from slot 1; slot 0 is never presented.
// 3. Back-pressure: ready_i=0 for 3 cycles with a group pending
//    -> outputs constant, valid_o=1; data unchanged after ready_i rises.
// 4. Overflow: ready_i=0, push DEPTH+1 groups
//    -> full_o=1 after the 4th group; overflow_o pulses once; the 5th group is never emitted.
// 5. Full push+pop: count=4, last slot of head transferred while a new group arrives
//    -> count stays 4; no overflow_o; the new group is emitted last in order.
// 6. Reset mid-drain: assert rst_i after the first block of a 2-slot group
//    -> valid_o=0 immediately; occupancy_o=0; no stale block after release.

Source files
------------

// File: rtl/te_block_scheduler_if.sv
// Group-in / block-out bundle between multiple_retirement, the block scheduler and the encoder.
// slave is the scheduler's view; master is the view of whatever drives and observes it.
interface te_block_scheduler_if #(
  parameter int unsigned N           = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IRETIRE_LEN = 3,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PRIV_LEN    = 2
);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [N-1:0]             valid_i;
  logic [N*IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]             ilastsize_i;
  logic [N*ITYPE_LEN-1:0]   itype_i;
  logic [N*XLEN-1:0]        iaddr_i;
  logic [CAUSE_LEN-1:0]     cause_i;
  logic [XLEN-1:0]          tval_i;
  logic [PRIV_LEN-1:0]      priv_i;
  logic                     ready_i;

  logic                     valid_o;
  logic [IRETIRE_LEN-1:0]   iretire_o;
  logic                     ilastsize_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [XLEN-1:0]          iaddr_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;
  logic                     full_o;
  logic                     overflow_o;
  logic [OccW-1:0]          occupancy_o;

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i, ready_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
           full_o, overflow_o, occupancy_o
  );

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i, ready_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
           full_o, overflow_o, occupancy_o
  );
endinterface

// File: rtl/te_block_scheduler.sv
// Buffers whole retirement groups in a FIFO and feeds their valid slots, lowest index first,
// to the trace encoder one block per cycle over a valid/ready handshake.
module te_block_scheduler #(
  parameter int unsigned N           = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IRETIRE_LEN = 3,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PRIV_LEN    = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  te_block_scheduler_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;
  localparam logic [OccW-1:0] DepthCnt = OccW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  logic [N-1:0]                  mask_mem      [DEPTH];
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_mem   [DEPTH];
  logic [N-1:0]                  ilastsize_mem [DEPTH];
  logic [N-1:0][ITYPE_LEN-1:0]   itype_mem     [DEPTH];
  logic [N-1:0][XLEN-1:0]        iaddr_mem     [DEPTH];
  logic [CAUSE_LEN-1:0]          cause_mem     [DEPTH];
  logic [XLEN-1:0]               tval_mem      [DEPTH];
  logic [PRIV_LEN-1:0]           priv_mem      [DEPTH];

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] count_q, count_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic            overflow_q, overflow_d;

  logic            serve, xfer, last, pop, push;
  logic [N-1:0]    head_mask, next_mask, upper;

  function automatic logic [SelW-1:0] first_set(input logic [N-1:0] mask);
    first_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) first_set = SelW'(i);
    end
  endfunction

  always_comb begin
    head_mask = mask_mem[rd_ptr_q];
    next_mask = mask_mem[rd_ptr_q + PtrW'(1)];
    upper     = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = head_mask[i] && (i > int'(sel_q));
    end
    serve = (state_q == StServe);
    xfer  = serve && bus.ready_i;
    last  = (upper == '0);
    pop   = xfer && last;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the incoming group.
    push  = (|bus.valid_i) && ((count_q != DepthCnt) || pop);
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + OccW'(1);
    else if (pop && !push) count_d = count_q - OccW'(1);
    overflow_d = (|bus.valid_i) && !push;

    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (push) begin
          state_d = StServe;
          sel_d   = first_set(bus.valid_i);
        end
      end
      StServe: begin
        if (xfer) begin
          if (!last) begin
            sel_d = first_set(upper);
          end else if (count_q > OccW'(1)) begin
            sel_d = first_set(next_mask);
          end else if (push) begin
            // The sole group leaves as a new one lands; the newcomer becomes the head.
            sel_d = first_set(bus.valid_i);
          end else begin
            state_d = StIdle;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sel_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mask_mem[wr_ptr_q]      <= bus.valid_i;
      iretire_mem[wr_ptr_q]   <= bus.iretire_i;
      ilastsize_mem[wr_ptr_q] <= bus.ilastsize_i;
      itype_mem[wr_ptr_q]     <= bus.itype_i;
      iaddr_mem[wr_ptr_q]     <= bus.iaddr_i;
      cause_mem[wr_ptr_q]     <= bus.cause_i;
      tval_mem[wr_ptr_q]      <= bus.tval_i;
      priv_mem[wr_ptr_q]      <= bus.priv_i;
    end
  end

  // Data is gated by the serving state so every output reads zero while reset holds.
  assign bus.valid_o     = serve;
  assign bus.iretire_o   = serve ? iretire_mem[rd_ptr_q][sel_q] : '0;
  assign bus.ilastsize_o = serve ? ilastsize_mem[rd_ptr_q][sel_q] : 1'b0;
  assign bus.itype_o     = serve ? itype_mem[rd_ptr_q][sel_q] : '0;
  assign bus.iaddr_o     = serve ? iaddr_mem[rd_ptr_q][sel_q] : '0;
  assign bus.cause_o     = serve ? cause_mem[rd_ptr_q] : '0;
  assign bus.tval_o      = serve ? tval_mem[rd_ptr_q] : '0;
  assign bus.priv_o      = serve ? priv_mem[rd_ptr_q] : '0;
  assign bus.full_o      = (count_q == DepthCnt);
  assign bus.overflow_o  = overflow_q;
  assign bus.occupancy_o = count_q;
endmodule

// File: tb/tb_te_block_scheduler.sv
// Bench for te_block_scheduler: directed vector table, hand-written corner sequences and a
// randomized run against a queue-of-groups reference model.
module tb_te_block_scheduler;
  localparam int unsigned N  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned IR = 3;
  localparam int unsigned IT = 3;
  localparam int unsigned CL = 5;
  localparam int unsigned XL = 32;
  localparam int unsigned PL = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  te_block_scheduler_if #(
    .N(N), .DEPTH(D), .IRETIRE_LEN(IR), .ITYPE_LEN(IT), .CAUSE_LEN(CL), .XLEN(XL), .PRIV_LEN(PL)
  ) bus ();

  te_block_scheduler #(
    .N(N), .DEPTH(D), .IRETIRE_LEN(IR), .ITYPE_LEN(IT), .CAUSE_LEN(CL), .XLEN(XL), .PRIV_LEN(PL)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0, a1;
    logic        rdy;
    logic        ev;
    logic [31:0] ea;
    int          eo;
    logic        ef, eov;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                     input logic rdy, input logic ev, input logic [31:0] ea, input int eo,
                     input logic ef, input logic eov);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.rdy = rdy; t.ev = ev; t.ea = ea; t.eo = eo;
    t.ef = ef; t.eov = eov;
    tbl.push_back(t);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [N-1:0]    mask;
    logic [N*IR-1:0] ir;
    logic [N-1:0]    ls;
    logic [N*IT-1:0] it;
    logic [N*XL-1:0] ia;
    logic [CL-1:0]   cause;
    logic [XL-1:0]   tval;
    logic [PL-1:0]   priv;
  } grp_t;
  grp_t mq[$];
  int   done_cnt;
  logic exp_ovf;

  function automatic int nth_set(input logic [N-1:0] m, input int n);
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        if (c == n) return i;
        c++;
      end
    end
    return 0;
  endfunction

  task automatic model_check();
    int s;
    chk("rnd_valid", 64'(bus.valid_o), 64'(mq.size() > 0));
    chk("rnd_occ", 64'(bus.occupancy_o), 64'(mq.size()));
    chk("rnd_full", 64'(bus.full_o), 64'(mq.size() == D));
    chk("rnd_ovf", 64'(bus.overflow_o), 64'(exp_ovf));
    if (mq.size() > 0) begin
      s = nth_set(mq[0].mask, done_cnt);
      chk("rnd_iaddr", 64'(bus.iaddr_o), 64'(mq[0].ia[s*XL +: XL]));
      chk("rnd_iretire", 64'(bus.iretire_o), 64'(mq[0].ir[s*IR +: IR]));
      chk("rnd_itype", 64'(bus.itype_o), 64'(mq[0].it[s*IT +: IT]));
      chk("rnd_ilastsize", 64'(bus.ilastsize_o), 64'(mq[0].ls[s]));
      chk("rnd_cause", 64'(bus.cause_o), 64'(mq[0].cause));
      chk("rnd_tval", 64'(bus.tval_o), 64'(mq[0].tval));
      chk("rnd_priv", 64'(bus.priv_o), 64'(mq[0].priv));
    end
  endtask

  task automatic model_update();
    grp_t g;
    bit   xfer, pop, push;
    xfer = (mq.size() > 0) && bus.ready_i;
    pop  = xfer && (done_cnt == $countones(mq[0].mask) - 1);
    push = (|bus.valid_i) && ((mq.size() < D) || pop);
    exp_ovf = (|bus.valid_i) && !push;
    g.mask = bus.valid_i; g.ir = bus.iretire_i; g.ls = bus.ilastsize_i; g.it = bus.itype_i;
    g.ia = bus.iaddr_i; g.cause = bus.cause_i; g.tval = bus.tval_i; g.priv = bus.priv_i;
    if (xfer) done_cnt++;
    if (pop) begin
      void'(mq.pop_front());
      done_cnt = 0;
    end
    if (push) mq.push_back(g);
  endtask

  task automatic clear_inputs();
    bus.valid_i = '0; bus.iretire_i = '0; bus.ilastsize_i = '0; bus.itype_i = '0;
    bus.iaddr_i = '0; bus.cause_i = '0; bus.tval_i = '0; bus.priv_i = '0; bus.ready_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_valid", 64'(bus.valid_o), 64'(0));
    chk("reset_occ", 64'(bus.occupancy_o), 64'(0));
    chk("reset_full", 64'(bus.full_o), 64'(0));
    chk("reset_ovf", 64'(bus.overflow_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single group, sparse mask, overflow, full push+pop.
    add(2'b11, 32'h8000_0000, 32'h8000_0010, 1, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 1, 1, 32'h8000_0000, 1, 0, 0);
    add(2'b00, 0, 0, 1, 1, 32'h8000_0010, 1, 0, 0);
    add(2'b10, 32'h1111_1111, 32'h8000_0020, 1, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 1, 1, 32'h8000_0020, 1, 0, 0);
    add(2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      add(2'b01, 32'hA000_0000 + 32'(i), 0, 0, i > 1, 32'hA000_0001, i - 1, i == 5, 0);
    add(2'b00, 0, 0, 0, 1, 32'hA000_0001, 4, 1, 1);
    add(2'b00, 0, 0, 1, 1, 32'hA000_0001, 4, 1, 0);
    for (int i = 2; i <= 4; i++) add(2'b00, 0, 0, 1, 1, 32'hA000_0000 + 32'(i), 5 - i, 0, 0);
    add(2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(2'b01, 32'hB000_0000 + 32'(i), 0, 0, i > 1, 32'hB000_0001, i - 1, 0, 0);
    add(2'b01, 32'hB000_0005, 0, 1, 1, 32'hB000_0001, 4, 1, 0);
    add(2'b00, 0, 0, 1, 1, 32'hB000_0002, 4, 1, 0);
    for (int i = 3; i <= 5; i++) add(2'b00, 0, 0, 1, 1, 32'hB000_0000 + 32'(i), 6 - i, 0, 0);
    add(2'b00, 0, 0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      bus.valid_i = tbl[k].v;
      bus.iaddr_i = {tbl[k].a1, tbl[k].a0};
      bus.ready_i = tbl[k].rdy;
      chk($sformatf("tbl%0d_valid", k), 64'(bus.valid_o), 64'(tbl[k].ev));
      chk($sformatf("tbl%0d_occ", k), 64'(bus.occupancy_o), 64'(tbl[k].eo));
      chk($sformatf("tbl%0d_full", k), 64'(bus.full_o), 64'(tbl[k].ef));
      chk($sformatf("tbl%0d_ovf", k), 64'(bus.overflow_o), 64'(tbl[k].eov));
      if (tbl[k].ev) chk($sformatf("tbl%0d_iaddr", k), 64'(bus.iaddr_o), 64'(tbl[k].ea));
      step();
    end

    // Back-pressure: outputs hold while ready_i is low.
    bus.valid_i = 2'b11; bus.iaddr_i = {32'hC000_0010, 32'hC000_0000};
    bus.iretire_i = {3'd5, 3'd3}; bus.itype_i = {3'd6, 3'd2}; bus.ilastsize_i = 2'b01;
    bus.cause_i = 5'h11; bus.tval_i = 32'hDEAD_BEEF; bus.priv_i = 2'd3; bus.ready_i = 1'b0;
    step();
    bus.valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(bus.valid_o), 64'(1));
      chk("bp_iaddr", 64'(bus.iaddr_o), 64'(32'hC000_0000));
      chk("bp_iretire", 64'(bus.iretire_o), 64'(3));
      chk("bp_itype", 64'(bus.itype_o), 64'(2));
      chk("bp_ilastsize", 64'(bus.ilastsize_o), 64'(1));
      chk("bp_tval", 64'(bus.tval_o), 64'(32'hDEAD_BEEF));
      step();
    end
    bus.ready_i = 1'b1;
    chk("bp_rise_iaddr", 64'(bus.iaddr_o), 64'(32'hC000_0000));
    step();
    chk("bp_slot1_iaddr", 64'(bus.iaddr_o), 64'(32'hC000_0010));
    chk("bp_slot1_iretire", 64'(bus.iretire_o), 64'(5));
    chk("bp_cause", 64'(bus.cause_o), 64'(5'h11));
    chk("bp_priv", 64'(bus.priv_o), 64'(3));
    step();
    chk("bp_done", 64'(bus.valid_o), 64'(0));

    // Reset in the middle of draining a two-slot group.
    bus.valid_i = 2'b11; bus.iaddr_i = {32'hD000_0010, 32'hD000_0000};
    step();
    bus.valid_i = '0;
    chk("rst_first", 64'(bus.iaddr_o), 64'(32'hD000_0000));
    step();
    chk("rst_second", 64'(bus.iaddr_o), 64'(32'hD000_0010));
    rst_i = 1'b1;
    #1;
    chk("rst_valid", 64'(bus.valid_o), 64'(0));
    chk("rst_occ", 64'(bus.occupancy_o), 64'(0));
    chk("rst_iaddr", 64'(bus.iaddr_o), 64'(0));
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_stale", 64'(bus.valid_o), 64'(0));
    end

    // Randomized run against the model.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    mq.delete();
    done_cnt = 0;
    exp_ovf  = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.valid_i     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      bus.iretire_i   = 6'($urandom);
      bus.ilastsize_i = 2'($urandom);
      bus.itype_i     = 6'($urandom);
      bus.iaddr_i     = {$urandom, $urandom};
      bus.cause_i     = 5'($urandom);
      bus.tval_i      = $urandom;
      bus.priv_i      = 2'($urandom);
      bus.ready_i     = ((cyc % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      model_check();
      model_update();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
